mem_wb_stage: RTL and testbench

MEM/WB pipeline register plus writeback stage of the 5-stage LC-3b pipeline, directly downstream of the memory stage. It captures the memory stage latch outputs when the memory stage completes (load_wb). It then selects the writeback value (ALU result, load word, sign-extended load byte or link PC) and drives the register file write port, the condition-code register and the forwarding path. It also keeps a retired-instruction counter for performance debug.

---
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register and writeback stage of the 5-stage LC-3b pipeline.
// Captures the memory stage latch outputs when the memory stage completes,
// selects the writeback value, drives the register file write port, updates
// the architectural NZP register and exposes the same write as a forwarding
// source. A retired-instruction counter is kept for performance debug.
//
// Ports:
//   clk, rst_n          pipeline clock / async active-low reset
//   load_wb             memory stage done this cycle: capture stage inputs
//   valid_in            memory stage holds a real instruction
//   address_in          effective address (bit 0 selects byte lane)
//   data_in             dcache read data
//   result_in           ALU / address result
//   new_pc_in           PC+2 / link value
//   dr_in               destination register
//   wb_sel_in           00 result, 01 load word, 10 load byte, 11 link PC
//   load_regfile_in     instruction writes the register file
//   load_cc_in          instruction sets condition codes
//   regfile_we/dest/data register file write port
//   cc                  architectural NZP register
//   fwd_valid/dr/data   forwarding source (mirror of the write port)
//   retired_count       wrapping count of valid instructions retired
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int         CNT_W    = 16,
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_wb,
  input  logic             valid_in,
  input  logic [15:0]      address_in,
  input  logic [15:0]      data_in,
  input  logic [15:0]      result_in,
  input  logic [15:0]      new_pc_in,
  input  logic [2:0]       dr_in,
  input  logic [1:0]       wb_sel_in,
  input  logic             load_regfile_in,
  input  logic             load_cc_in,
  output logic             regfile_we,
  output logic [2:0]       regfile_dest,
  output logic [15:0]      regfile_data,
  output logic [2:0]       cc,
  output logic             fwd_valid,
  output logic [2:0]       fwd_dr,
  output logic [15:0]      fwd_data,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    WB_RESULT    = 2'b00,
    WB_LOAD_WORD = 2'b01,
    WB_LOAD_BYTE = 2'b10,
    WB_LINK_PC   = 2'b11
  } wb_sel_e;

  // Stage registers
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] result_q;
  logic [15:0] pc_q;
  logic [2:0]  dr_q;
  wb_sel_e     sel_q;
  logic        ldreg_q;
  logic        ldcc_q;
  logic        valid_q;

  logic [15:0] wb_data;
  logic [7:0]  ld_byte;
  logic [2:0]  cc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  // NOTE: data registers are reset too (not only valid_q) so no output is ever
  // X, even the write data/dest seen while regfile_we is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
      pc_q     <= '0;
      dr_q     <= '0;
      sel_q    <= WB_RESULT;
      ldreg_q  <= 1'b0;
      ldcc_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (load_wb) begin
      addr_q   <= address_in;
      data_q   <= data_in;
      result_q <= result_in;
      pc_q     <= new_pc_in;
      dr_q     <= dr_in;
      sel_q    <= wb_sel_e'(wb_sel_in);
      ldreg_q  <= load_regfile_in;
      ldcc_q   <= load_cc_in;
      valid_q  <= valid_in;
    end else begin
      // Memory stalled: insert a bubble so the held instruction cannot
      // retire a second time. Data registers simply hold.
      valid_q  <= 1'b0;
    end
  end

  // Byte lane picked by the low address bit, then sign-extended.
  assign ld_byte = addr_q[0] ? data_q[15:8] : data_q[7:0];

  // NOTE: every path of the case assigns wb_data, and a default is assigned
  // first anyway, so no latch can be inferred.
  always_comb begin
    wb_data = result_q;
    unique case (sel_q)
      WB_RESULT:    wb_data = result_q;
      WB_LOAD_WORD: wb_data = data_q;
      WB_LOAD_BYTE: wb_data = {{8{ld_byte[7]}}, ld_byte};
      WB_LINK_PC:   wb_data = pc_q;
    endcase
  end

  // NZP from the writeback value: exactly one bit is ever set.
  always_comb begin
    cc_next    = 3'b000;
    cc_next[2] = wb_data[15];
    cc_next[1] = (wb_data == 16'h0000);
    cc_next[0] = !wb_data[15] && (wb_data != 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (valid_q && ldcc_q) begin
      cc <= cc_next;
    end
  end

  // Stores and branches (ldreg_q=0) still count as retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (valid_q) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Write enable is combinational from valid_q, so it drops the moment reset
  // clears valid_q rather than at the next clock.
  assign regfile_we   = valid_q & ldreg_q;
  assign regfile_dest = dr_q;
  assign regfile_data = wb_data;

  assign fwd_valid = regfile_we;
  assign fwd_dr    = regfile_dest;
  assign fwd_data  = regfile_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed self-checking bench for mem_wb_stage. Inputs are driven 1 time unit
// after the rising edge; outputs are sampled at that same point, when all
// registered state from the edge has settled.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        load_wb;
  logic        valid_in;
  logic [15:0] address_in;
  logic [15:0] data_in;
  logic [15:0] result_in;
  logic [15:0] new_pc_in;
  logic [2:0]  dr_in;
  logic [1:0]  wb_sel_in;
  logic        load_regfile_in;
  logic        load_cc_in;
  logic        regfile_we;
  logic [2:0]  regfile_dest;
  logic [15:0] regfile_data;
  logic [2:0]  cc;
  logic        fwd_valid;
  logic [2:0]  fwd_dr;
  logic [15:0] fwd_data;
  logic [15:0] retired_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_count;

  mem_wb_stage #(.CNT_W(16), .CC_RESET(3'b010)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_wb         (load_wb),
    .valid_in        (valid_in),
    .address_in      (address_in),
    .data_in         (data_in),
    .result_in       (result_in),
    .new_pc_in       (new_pc_in),
    .dr_in           (dr_in),
    .wb_sel_in       (wb_sel_in),
    .load_regfile_in (load_regfile_in),
    .load_cc_in      (load_cc_in),
    .regfile_we      (regfile_we),
    .regfile_dest    (regfile_dest),
    .regfile_data    (regfile_data),
    .cc              (cc),
    .fwd_valid       (fwd_valid),
    .fwd_dr          (fwd_dr),
    .fwd_data        (fwd_data),
    .retired_count   (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lw, input logic v, input logic [1:0] sel,
                       input logic [15:0] addr, input logic [15:0] data,
                       input logic [15:0] res, input logic [15:0] pc,
                       input logic [2:0] dr, input logic ldreg, input logic ldcc);
    load_wb = lw; valid_in = v; wb_sel_in = sel; address_in = addr;
    data_in = data; result_in = res; new_pc_in = pc; dr_in = dr;
    load_regfile_in = ldreg; load_cc_in = ldcc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_count = 16'h0000;
  endtask

  task automatic test_reset();
    idle();
    apply_reset();
    n_checks++; if (retired_count !== 16'h0000) begin n_fail++; $display("FAIL reset_init_count: got %h want 0000", retired_count); end
    n_checks++; if (cc !== 3'b010) begin n_fail++; $display("FAIL reset_init_cc: got %b want 010", cc); end
    // Put a writing instruction into WB, then assert reset mid-cycle.
    drive(1'b1, 1'b1, 2'b00, 16'h0, 16'h0, 16'h5555, 16'h0, 3'd4, 1'b1, 1'b1);
    step();
    idle();
    n_checks++; if (regfile_we !== 1'b1) begin n_fail++; $display("FAIL reset_pre_we: got %b want 1", regfile_we); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (regfile_we !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_async_we: got we=%b fwd=%b want 0/0", regfile_we, fwd_valid); end
    n_checks++; if (cc !== 3'b010) begin n_fail++; $display("FAIL reset_async_cc: got %b want 010", cc); end
    n_checks++; if (retired_count !== 16'h0000) begin n_fail++; $display("FAIL reset_async_count: got %h want 0000", retired_count); end
    n_checks++; if (regfile_data !== 16'h0000 || regfile_dest !== 3'd0) begin n_fail++; $display("FAIL reset_async_data: got %h/%0d want 0000/0", regfile_data, regfile_dest); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    exp_count = 16'h0000;
    n_checks++; if (regfile_we !== 1'b0 || retired_count !== 16'h0000) begin n_fail++; $display("FAIL reset_idle: got we=%b cnt=%h want 0/0000", regfile_we, retired_count); end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b1, 2'b00, 16'h0, 16'h0, 16'h8001, 16'h0, 3'd3, 1'b1, 1'b1);
    step();
    idle();
    n_checks++; if (regfile_we !== 1'b1 || regfile_dest !== 3'd3 || regfile_data !== 16'h8001) begin n_fail++; $display("FAIL alu_write: got we=%b dest=%0d data=%h want 1/3/8001", regfile_we, regfile_dest, regfile_data); end
    n_checks++; if (fwd_valid !== 1'b1 || fwd_dr !== 3'd3 || fwd_data !== 16'h8001) begin n_fail++; $display("FAIL alu_fwd: got v=%b dr=%0d data=%h want 1/3/8001", fwd_valid, fwd_dr, fwd_data); end
    n_checks++; if (cc !== 3'b010 || retired_count !== exp_count) begin n_fail++; $display("FAIL alu_early_cc: got cc=%b cnt=%h want 010/%h", cc, retired_count, exp_count); end
    step();
    exp_count++;
    n_checks++; if (cc !== 3'b100) begin n_fail++; $display("FAIL alu_cc: got %b want 100", cc); end
    n_checks++; if (retired_count !== exp_count || regfile_we !== 1'b0) begin n_fail++; $display("FAIL alu_count: got cnt=%h we=%b want %h/0", retired_count, regfile_we, exp_count); end
  endtask

  task automatic test_load_byte();
    drive(1'b1, 1'b1, 2'b10, 16'h3001, 16'hF27A, 16'h0, 16'h0, 3'd5, 1'b1, 1'b1);
    step();
    n_checks++; if (regfile_data !== 16'hFFF2 || regfile_we !== 1'b1) begin n_fail++; $display("FAIL ldb_high: got data=%h we=%b want FFF2/1", regfile_data, regfile_we); end
    drive(1'b1, 1'b1, 2'b10, 16'h3000, 16'hF27A, 16'h0, 16'h0, 3'd5, 1'b1, 1'b1);
    step();
    exp_count++;
    idle();
    n_checks++; if (regfile_data !== 16'h007A) begin n_fail++; $display("FAIL ldb_low: got %h want 007A", regfile_data); end
    n_checks++; if (cc !== 3'b100) begin n_fail++; $display("FAIL ldb_high_cc: got %b want 100", cc); end
    step();
    exp_count++;
    n_checks++; if (cc !== 3'b001 || retired_count !== exp_count) begin n_fail++; $display("FAIL ldb_low_cc: got cc=%b cnt=%h want 001/%h", cc, retired_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    // Load word of zero, then positive ALU result on the very next cycle.
    drive(1'b1, 1'b1, 2'b01, 16'h0, 16'h0000, 16'hAAAA, 16'h0, 3'd1, 1'b1, 1'b1);
    step();
    n_checks++; if (regfile_we !== 1'b1 || regfile_dest !== 3'd1 || regfile_data !== 16'h0000) begin n_fail++; $display("FAIL b2b_first: got we=%b dest=%0d data=%h want 1/1/0000", regfile_we, regfile_dest, regfile_data); end
    drive(1'b1, 1'b1, 2'b00, 16'h0, 16'h0, 16'h7FFF, 16'h0, 3'd2, 1'b1, 1'b1);
    step();
    exp_count++;
    idle();
    n_checks++; if (regfile_we !== 1'b1 || regfile_dest !== 3'd2 || regfile_data !== 16'h7FFF) begin n_fail++; $display("FAIL b2b_second: got we=%b dest=%0d data=%h want 1/2/7FFF", regfile_we, regfile_dest, regfile_data); end
    n_checks++; if (cc !== 3'b010 || retired_count !== exp_count) begin n_fail++; $display("FAIL b2b_zero_cc: got cc=%b cnt=%h want 010/%h", cc, retired_count, exp_count); end
    step();
    exp_count++;
    n_checks++; if (cc !== 3'b001 || retired_count !== exp_count) begin n_fail++; $display("FAIL b2b_pos_cc: got cc=%b cnt=%h want 001/%h", cc, retired_count, exp_count); end
  endtask

  task automatic test_mem_stall();
    int we_cycles = 0;
    drive(1'b1, 1'b1, 2'b00, 16'h0, 16'h0, 16'h8234, 16'h0, 3'd6, 1'b1, 1'b1);
    step();
    // Memory now stalls: inputs change but must not be captured.
    drive(1'b0, 1'b1, 2'b00, 16'h0, 16'h0, 16'h0001, 16'h0, 3'd0, 1'b1, 1'b1);
    if (regfile_we === 1'b1) we_cycles++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (regfile_we === 1'b1) we_cycles++;
    end
    exp_count++;
    n_checks++; if (we_cycles !== 1) begin n_fail++; $display("FAIL stall_we_cycles: got %0d want 1", we_cycles); end
    n_checks++; if (retired_count !== exp_count) begin n_fail++; $display("FAIL stall_count: got %h want %h", retired_count, exp_count); end
    n_checks++; if (cc !== 3'b100 || regfile_data !== 16'h8234) begin n_fail++; $display("FAIL stall_hold: got cc=%b data=%h want 100/8234", cc, regfile_data); end
    idle();
  endtask

  task automatic test_link_bubble();
    drive(1'b1, 1'b1, 2'b11, 16'h0, 16'h0, 16'h0, 16'h0102, 3'd7, 1'b1, 1'b0);
    step();
    n_checks++; if (regfile_we !== 1'b1 || regfile_dest !== 3'd7 || regfile_data !== 16'h0102) begin n_fail++; $display("FAIL link_write: got we=%b dest=%0d data=%h want 1/7/0102", regfile_we, regfile_dest, regfile_data); end
    // Bubble captured with load_wb=1.
    drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0000, 16'h0, 3'd2, 1'b1, 1'b1);
    step();
    exp_count++;
    idle();
    n_checks++; if (regfile_we !== 1'b0 || fwd_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_we: got we=%b fwd=%b want 0/0", regfile_we, fwd_valid); end
    n_checks++; if (cc !== 3'b100) begin n_fail++; $display("FAIL link_cc_hold: got %b want 100", cc); end
    step();
    n_checks++; if (cc !== 3'b100 || retired_count !== exp_count) begin n_fail++; $display("FAIL bubble_no_retire: got cc=%b cnt=%h want 100/%h", cc, retired_count, exp_count); end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    // Non-writing instructions (stores) every cycle: each still retires.
    drive(1'b1, 1'b1, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (retired_count !== 16'h0004 || regfile_we !== 1'b0) begin n_fail++; $display("FAIL store_retire: got cnt=%h we=%b want 0004/0", retired_count, regfile_we); end
    for (int i = 5; i < 65536; i++) step();
    n_checks++; if (retired_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want FFFF", retired_count); end
    idle();
    step();
    n_checks++; if (retired_count !== 16'h0000) begin n_fail++; $display("FAIL wrap: got %h want 0000", retired_count); end
    step();
    n_checks++; if (retired_count !== 16'h0000 || cc !== 3'b010) begin n_fail++; $display("FAIL wrap_hold: got cnt=%h cc=%b want 0000/010", retired_count, cc); end
  endtask

  initial begin
    rst_n = 1'b0;
    exp_count = 16'h0000;
    idle();
    test_reset();
    test_alu_write();
    test_load_byte();
    test_back_to_back();
    test_mem_stall();
    test_link_bubble();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
